// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - single-clock FIFO sequencer for the fifo_memory array.
// Optional almost_full/almost_empty flags are enabled by defining FIFO_ALMOST_EN.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

  typedef enum logic {CLR = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  logic          run_act, push_acc, pop_acc, clear;

  always_ff @(posedge clk) begin
    if (rst) state <= CLR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR:     state_nxt = RUN;
      RUN:     if (flush) state_nxt = CLR;
      default: state_nxt = CLR;
    endcase
  end

  always_comb begin
    mem_ren = (state == RUN);
  end

  // A flush cycle swallows any push/pop presented alongside it.
  assign run_act  = (state == RUN) && !flush;
  assign pop_acc  = run_act && pop && !empty;
  assign push_acc = run_act && push && (!full || pop_acc);
  assign clear    = rst || ((state == RUN) && flush);

  assign wptr_nxt = wptr + PW'(push_acc);
  assign rptr_nxt = rptr + PW'(pop_acc);

  always_comb begin
    count_nxt = count;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count + PW'(1);
      2'b01:   count_nxt = count - PW'(1);
      default: count_nxt = count;
    endcase
  end

  assign mem_wen   = push_acc;
  assign mem_waddr = wptr[ADDR_WIDTH-1:0];
  assign mem_wdata = push_data;
  assign mem_raddr = rptr[ADDR_WIDTH-1:0];
  assign pop_data  = mem_rdata;

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      pop_valid <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      count     <= count_nxt;
      empty     <= (wptr_nxt == rptr_nxt);
      full      <= (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                   (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
      pop_valid <= pop_acc;
    end
  end

  // Error flags survive a flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (run_act && push && full && !pop_acc) overflow <= 1'b1;
      if (run_act && pop && empty)             underflow <= 1'b1;
    end
  end

`ifdef FIFO_ALMOST_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt >= AF_L);
      almost_empty <= (count_nxt <= AE_L);
    end
  end
`else
  logic unused_levels;
  assign unused_levels = ^{AF_L, AE_L};
  assign almost_full   = 1'b0;
  assign almost_empty  = 1'b0;
`endif

endmodule
